// File: rtl/vcm_sweep_gen.sv
// Stepped VCM position sweep generator for the auto-focus path.
// Ramps STEP between latched LO/HI limits in triangle, sawtooth or single-shot modes.
module vcm_sweep_gen #(
    parameter int unsigned W     = 10,
    parameter int unsigned DIV_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [W-1:0]     i_lo,
    input  logic [W-1:0]     i_hi,
    input  logic [W-1:0]     i_inc,
    input  logic [DIV_W-1:0] i_div,
    output logic [W-1:0]     o_step,
    output logic             o_dir,
    output logic             o_turn,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_TRI  = 2'd0;
    localparam logic [1:0] MODE_SAW  = 2'd1;
    localparam logic [1:0] MODE_TRI1 = 2'd3;

    state_t           r_state;
    logic [1:0]       r_mode;
    logic [W-1:0]     r_lo;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_inc;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;

    logic [W-1:0]     w_inc;
    logic [W:0]       w_sum;
    logic [W:0]       w_diff;
    logic [W-1:0]     w_up_next;
    logic [W-1:0]     w_dn_next;
    logic             w_sweeping;
    logic             w_tick;

    // Saturating next positions computed one bit wider so the limits never wrap.
    always_comb begin
        w_inc      = (r_inc == '0) ? W'(1) : r_inc;
        w_sum      = {1'b0, o_step} + {1'b0, w_inc};
        w_diff     = {1'b0, o_step} - {1'b0, w_inc};
        w_up_next  = (w_sum > {1'b0, r_hi}) ? r_hi : w_sum[W-1:0];
        w_dn_next  = (w_diff[W] || (w_diff[W-1:0] < r_lo)) ? r_lo : w_diff[W-1:0];
        w_sweeping = (r_state == S_UP) || (r_state == S_DOWN);
        w_tick     = w_sweeping && i_en && (r_cnt == r_div);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_mode  <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_inc   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            o_step  <= '0;
            o_dir   <= 1'b0;
            o_turn  <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_turn <= 1'b0;
            if (i_start) begin
                // A start discards any tick due on this edge.
                r_mode <= i_mode;
                r_lo   <= i_lo;
                r_hi   <= i_hi;
                r_inc  <= i_inc;
                r_div  <= i_div;
                r_cnt  <= '0;
                o_step <= i_lo;
                o_dir  <= 1'b0;
                if (i_lo >= i_hi) begin
                    r_state <= S_FIN;
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                end else begin
                    r_state <= S_UP;
                    o_done  <= 1'b0;
                    o_busy  <= 1'b1;
                end
            end else if (w_sweeping && i_en) begin
                if (!w_tick) begin
                    r_cnt <= r_cnt + DIV_W'(1);
                end else begin
                    r_cnt <= '0;
                    case (r_state)
                        S_UP: begin
                            if (o_step < r_hi) begin
                                o_step <= w_up_next;
                            end else if ((r_mode == MODE_TRI) || (r_mode == MODE_TRI1)) begin
                                o_dir   <= 1'b1;
                                o_step  <= w_dn_next;
                                o_turn  <= 1'b1;
                                r_state <= S_DOWN;
                            end else if (r_mode == MODE_SAW) begin
                                o_step <= r_lo;
                                o_turn <= 1'b1;
                            end else begin
                                r_state <= S_FIN;
                                o_done  <= 1'b1;
                                o_busy  <= 1'b0;
                            end
                        end
                        S_DOWN: begin
                            if (o_step > r_lo) begin
                                o_step <= w_dn_next;
                            end else if (r_mode == MODE_TRI) begin
                                o_dir   <= 1'b0;
                                o_step  <= w_up_next;
                                o_turn  <= 1'b1;
                                r_state <= S_UP;
                            end else begin
                                // Single triangle ends on LO still descending.
                                r_state <= S_FIN;
                                o_done  <= 1'b1;
                                o_busy  <= 1'b0;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_vcm_sweep_gen.sv
// Bench for vcm_sweep_gen: directed vector table, corner sequences and random runs
// checked against a precomputed position-list model.
module tb_vcm_sweep_gen;

    localparam int unsigned W     = 16;
    localparam int unsigned DIV_W = 4;
    localparam int          CAP   = 512;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             en;
    logic [1:0]       mode;
    logic [W-1:0]     lo;
    logic [W-1:0]     hi;
    logic [W-1:0]     inc;
    logic [DIV_W-1:0] div;
    logic [W-1:0]     step;
    logic             dir;
    logic             turn;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    vcm_sweep_gen #(.W(W), .DIV_W(DIV_W)) u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_en    (en),
        .i_start (start),
        .i_mode  (mode),
        .i_lo    (lo),
        .i_hi    (hi),
        .i_inc   (inc),
        .i_div   (div),
        .o_step  (step),
        .o_dir   (dir),
        .o_turn  (turn),
        .o_busy  (busy),
        .o_done  (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: list of positions visited after START, indexed by tick number.
    int q_step[$];
    bit q_dir[$];
    bit q_turn[$];
    int m_step = 0;
    bit m_dir  = 0;
    bit m_turn = 0;
    bit m_busy = 0;
    bit m_done = 0;
    bit m_act  = 0;
    int m_e    = 0;
    int m_per  = 1;

    function automatic void push(int v, bit d, bit t);
        q_step.push_back(v);
        q_dir.push_back(d);
        q_turn.push_back(t);
    endfunction

    function automatic void build(int md, int l, int h, int s);
        int v;
        bit pend;
        q_step.delete();
        q_dir.delete();
        q_turn.delete();
        pend = 0;
        if (s == 0) s = 1;
        push(l, 0, 0);
        while (q_step.size() < CAP) begin
            while (q_step[$] < h && q_step.size() < CAP) begin
                v = q_step[$] + s;
                if (v > h) v = h;
                push(v, 0, pend);
                pend = 0;
            end
            if (q_step.size() >= CAP || md == 2) break;
            if (md == 1) begin
                push(l, 0, 1);
                continue;
            end
            pend = 1;
            while (q_step[$] > l && q_step.size() < CAP) begin
                v = q_step[$] - s;
                if (v < l) v = l;
                push(v, 1, pend);
                pend = 0;
            end
            if (md == 3) break;
            pend = 1;
        end
    endfunction

    function automatic void model_edge();
        int k;
        m_turn = 0;
        if (rst) begin
            m_step = 0; m_dir = 0; m_busy = 0; m_done = 0; m_act = 0;
        end else if (start) begin
            m_step = int'(lo);
            m_dir  = 0;
            m_e    = 0;
            m_per  = int'(div) + 1;
            if (lo >= hi) begin
                m_act = 0; m_busy = 0; m_done = 1;
            end else begin
                m_act = 1; m_busy = 1; m_done = 0;
                build(int'(mode), int'(lo), int'(hi), int'(inc));
            end
        end else if (m_act && en) begin
            m_e++;
            if (m_e % m_per == 0) begin
                k = m_e / m_per;
                if (k >= q_step.size()) begin
                    m_act = 0; m_busy = 0; m_done = 1;
                end else begin
                    m_step = q_step[k];
                    m_dir  = q_dir[k];
                    m_turn = q_turn[k];
                end
            end
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic chk(string nm, int es, bit ed, bit et, bit eb, bit edn);
        n_cmp++;
        if (step !== W'(es) || dir !== ed || turn !== et || busy !== eb || done !== edn) begin
            n_bad++;
            $display("FAIL %s: got step=%0h dir=%0b turn=%0b busy=%0b done=%0b, expected step=%0h dir=%0b turn=%0b busy=%0b done=%0b",
                     nm, step, dir, turn, busy, done, W'(es), ed, et, eb, edn);
        end
    endtask

    task automatic chk_model(string nm);
        chk(nm, m_step, m_dir, m_turn, m_busy, m_done);
    endtask

    typedef struct {
        bit       rst;
        bit       start;
        bit       en;
        bit [1:0] mode;
        int       lo;
        int       hi;
        int       inc;
        int       dv;
        int       e_step;
        bit       e_dir;
        bit       e_turn;
        bit       e_busy;
        bit       e_done;
    } vec_t;

    function automatic vec_t mk(bit r, bit s, bit e, bit [1:0] md, int l, int h, int i, int d,
                                int es, bit ed, bit et, bit eb, bit edn);
        vec_t v;
        v.rst = r; v.start = s; v.en = e; v.mode = md;
        v.lo = l; v.hi = h; v.inc = i; v.dv = d;
        v.e_step = es; v.e_dir = ed; v.e_turn = et; v.e_busy = eb; v.e_done = edn;
        return v;
    endfunction

    task automatic apply(vec_t v);
        rst   = v.rst;
        start = v.start;
        en    = v.en;
        mode  = v.mode;
        lo    = W'(v.lo);
        hi    = W'(v.hi);
        inc   = W'(v.inc);
        div   = DIV_W'(v.dv);
    endtask

    vec_t tbl[$];
    int   saw[3];
    int   n_edges;

    initial begin
        rst = 1'b1; start = 1'b0; en = 1'b0; mode = '0;
        lo = '0; hi = '0; inc = '0; div = '0;
        saw[0] = 2; saw[1] = 6; saw[2] = 9;

        // Reset, then idle with garbage config (ignored without START)
        tbl.push_back(mk(1,0,0, 0,  0,  0, 0,0,  0,0,0,0,0));
        tbl.push_back(mk(1,0,1, 0,  0,  0, 0,0,  0,0,0,0,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,1, 1, 33, 50, 2,9,  0,0,0,0,0));
        // Triangle 4..10 step 3
        tbl.push_back(mk(0,1,1, 0,  4, 10, 3,0,  4,0,0,1,0));
        tbl.push_back(mk(0,0,1, 1, 99,  1, 0,9,  7,0,0,1,0));
        tbl.push_back(mk(0,0,1, 1, 99,  1, 0,9, 10,0,0,1,0));
        tbl.push_back(mk(0,0,1, 1, 99,  1, 0,9,  7,1,1,1,0));
        tbl.push_back(mk(0,0,1, 1, 99,  1, 0,9,  4,1,0,1,0));
        tbl.push_back(mk(0,0,1, 1, 99,  1, 0,9,  7,0,1,1,0));
        tbl.push_back(mk(0,0,1, 1, 99,  1, 0,9, 10,0,0,1,0));
        tbl.push_back(mk(0,0,1, 1, 99,  1, 0,9,  7,1,1,1,0));
        tbl.push_back(mk(0,0,0, 1, 99,  1, 0,9,  7,1,0,1,0));
        // Restart on a tick edge with LO==HI
        tbl.push_back(mk(0,1,1, 0,  7,  7, 3,0,  7,0,0,0,1));
        tbl.push_back(mk(0,0,1, 0,  1,  9, 3,0,  7,0,0,0,1));
        // Single triangle 0..5 step 5
        tbl.push_back(mk(0,1,1, 3,  0,  5, 5,0,  0,0,0,1,0));
        tbl.push_back(mk(0,0,1, 0,  0,  0, 0,0,  5,0,0,1,0));
        tbl.push_back(mk(0,0,1, 0,  0,  0, 0,0,  0,1,1,1,0));
        tbl.push_back(mk(0,0,1, 0,  0,  0, 0,0,  0,1,0,0,1));
        tbl.push_back(mk(0,0,1, 0,  0,  0, 0,0,  0,1,0,0,1));
        // Full-range ramp, no wrap past FFFF
        tbl.push_back(mk(0,1,1, 2,  0,'hFFFF,'h8000,0,      0,0,0,1,0));
        tbl.push_back(mk(0,0,1, 0,  0,  0, 0,0, 'h8000,0,0,1,0));
        tbl.push_back(mk(0,0,1, 0,  0,  0, 0,0, 'hFFFF,0,0,1,0));
        tbl.push_back(mk(0,0,1, 0,  0,  0, 0,0, 'hFFFF,0,0,0,1));
        // INC=0 behaves as 1
        tbl.push_back(mk(0,1,1, 2,  3,  5, 0,0,  3,0,0,1,0));
        tbl.push_back(mk(0,0,1, 0,  0,  0, 0,0,  4,0,0,1,0));
        tbl.push_back(mk(0,0,1, 0,  0,  0, 0,0,  5,0,0,1,0));
        tbl.push_back(mk(0,0,1, 0,  0,  0, 0,0,  5,0,0,0,1));
        // Reset mid-sweep, and reset beating START
        tbl.push_back(mk(0,1,1, 0,  4, 10, 3,0,  4,0,0,1,0));
        tbl.push_back(mk(0,0,1, 0,  0,  0, 0,0,  7,0,0,1,0));
        tbl.push_back(mk(1,0,1, 0,  0,  0, 0,0,  0,0,0,0,0));
        tbl.push_back(mk(1,1,1, 0,  4, 10, 3,0,  0,0,0,0,0));
        tbl.push_back(mk(0,0,1, 0,  4, 10, 3,0,  0,0,0,0,0));

        foreach (tbl[i]) begin
            apply(tbl[i]);
            cyc();
            chk($sformatf("vec%0d", i), tbl[i].e_step, tbl[i].e_dir, tbl[i].e_turn,
                tbl[i].e_busy, tbl[i].e_done);
        end

        // Sawtooth 2..9 step 4, each value held DIV+1=3 cycles
        rst = 0; en = 1; start = 1; mode = 2'd1;
        lo = W'(2); hi = W'(9); inc = W'(4); div = DIV_W'(2);
        cyc();
        chk("saw_start", 2, 0, 0, 1, 0);
        start = 0;
        for (int i = 1; i < 18; i++) begin
            cyc();
            chk($sformatf("saw%0d", i), saw[(i / 3) % 3], 0,
                (i % 3 == 0) && ((i / 3) % 3 == 0), 1, 0);
        end

        // Single triangle with a 4-cycle EN gap: completion slips by exactly 4 edges
        start = 1; mode = 2'd3; lo = W'(0); hi = W'(5); inc = W'(5); div = DIV_W'(1);
        cyc();
        chk_model("pause_start");
        start = 0;
        n_edges = 31;
        for (int n = 1; n <= 30; n++) begin
            en = (n >= 2 && n <= 5) ? 1'b0 : 1'b1;
            cyc();
            chk_model($sformatf("pause%0d", n));
            if (done) begin
                n_edges = n;
                break;
            end
        end
        n_cmp++;
        if (n_edges != 10) begin
            n_bad++;
            $display("FAIL en_pause_len: done after %0d edges, expected 10", n_edges);
        end

        // Random runs against the model
        for (int r = 0; r < 40; r++) begin
            rst = 0; en = 1; start = 1;
            mode = 2'($urandom_range(0, 3));
            lo   = W'($urandom_range(0, 40));
            hi   = ($urandom_range(0, 4) == 0) ? W'($urandom) : lo + W'($urandom_range(0, 60));
            inc  = ($urandom_range(0, 5) == 0) ? W'($urandom) : W'($urandom_range(0, 20));
            div  = DIV_W'($urandom_range(0, 3));
            cyc();
            chk_model($sformatf("rnd%0d_start", r));
            for (int c = 0; c < int'($urandom_range(20, 80)); c++) begin
                start = ($urandom_range(0, 59) == 0);
                rst   = ($urandom_range(0, 99) == 0);
                en    = ($urandom_range(0, 9) != 0);
                mode  = 2'($urandom_range(0, 3));
                lo    = W'($urandom_range(0, 40));
                hi    = lo + W'($urandom_range(0, 60));
                inc   = W'($urandom_range(0, 20));
                div   = DIV_W'($urandom_range(0, 3));
                cyc();
                chk_model($sformatf("rnd%0d_c%0d", r, c));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
